// File: rtl/uart_rx_stream.sv
// rtl/uart_rx_stream.sv - 8N1 UART receiver presenting bytes on a valid/ready stream
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each bit decision is the 2-of-3 majority of the samples at
//               mid-1, mid and mid+1, so every decision lands one cycle later
//   undefined : single sample at the bit mid-point
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx         serial line, idle high, already synchronized by the parent
//   rx_data    received byte (LSB first on the wire), stable while rx_valid
//   rx_valid   rx_data holds an unconsumed byte
//   rx_ready   consumer takes the byte when rx_valid && rx_ready
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    one-cycle pulse when a byte completes while the slot is full

module uart_rx_stream #(
    parameter int PRESCALER = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(PRESCALER);

    // The counter holds the number of cycles remaining until the next
    // decision; a decision is taken when it reaches zero. Loading N-1
    // keeps a full bit period inside $clog2(PRESCALER) bits.
    localparam logic [CW-1:0] BIT_RELOAD = CW'(PRESCALER - 1);
`ifdef UART_RX_MAJORITY_EN
    // One extra cycle so the decision sees the mid+1 sample.
    localparam logic [CW-1:0] START_LOAD = CW'(PRESCALER / 2);
`else
    localparam logic [CW-1:0] START_LOAD = CW'(PRESCALER / 2 - 1);
`endif

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            bit_val;
    logic            mid;
    logic            take_byte;
    logic            drop_byte;
    logic            bad_stop;
    logic            handshake;

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rx one cycle ago, hist[1] two cycles ago.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx};
        end
    end

    assign bit_val = (rx & hist[0]) | (rx & hist[1]) | (hist[0] & hist[1]);
`else
    assign bit_val = rx;
`endif

    assign mid       = (cnt == '0);
    assign handshake = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take_byte  = 1'b0;
        drop_byte  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (rx) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!rx) begin
                    cnt_next   = START_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (!mid) begin
                    cnt_next = cnt - 1'b1;
                end else if (bit_val) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = BIT_RELOAD;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!mid) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    cnt_next = BIT_RELOAD;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (!mid) begin
                    cnt_next = cnt - 1'b1;
                end else if (!bit_val) begin
                    // A low stop bit may be a break; wait for the line to recover.
                    bad_stop   = 1'b1;
                    state_next = WAIT_IDLE;
                end else begin
                    // Return early so the next start edge can be caught anywhere
                    // in the second half of the stop bit.
                    state_next = IDLE;
                    if (rx_valid && !rx_ready) begin
                        drop_byte = 1'b1;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            frame_err <= bad_stop;
            overrun   <= drop_byte;
            if (state == START) begin
                idx <= 3'd0;
            end
            if (state == DATA && mid) begin
                shift <= {bit_val, shift[7:1]};
                idx   <= idx + 3'd1;
            end
            // A handshake in the same cycle frees the slot, so loading wins.
            if (take_byte) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (handshake) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb/tb_uart_rx_stream.sv - scoreboard bench for uart_rx_stream

module tb_uart_rx_stream;

    localparam int P = 24;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = P / 2 + 9 * P + 2;
`else
    localparam int LAT = P / 2 + 9 * P + 1;
`endif

    localparam int K_TIMED   = 0;
    localparam int K_UNTIMED = 1;
    localparam int K_FE      = 2;
    localparam int K_OV      = 3;
    localparam int K_NONE    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx_stream #(.PRESCALER(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t bq[$];
    int   eq[$];
    exp_t e;
    int   k;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a byte or a pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err || overrun) begin
                chk("err_exclusive", int'(frame_err & overrun), 0);
            end
            if (frame_err) begin
                chk("frame_err_expected", int'(eq.size() > 0), 1);
                if (eq.size() > 0) begin
                    k = eq.pop_front();
                    chk("err_kind_frame_err", k, K_FE);
                end
            end
            if (overrun) begin
                chk("overrun_expected", int'(eq.size() > 0), 1);
                if (eq.size() > 0) begin
                    k = eq.pop_front();
                    chk("err_kind_overrun", k, K_OV);
                end
            end
            if (rx_valid && rx_ready) begin
                chk("byte_expected", int'(bq.size() > 0), 1);
                if (bq.size() > 0) begin
                    e = bq.pop_front();
                    chk("rx_data", int'(rx_data), int'(e.data));
                    if (e.due >= 0) begin
                        chk("rx_valid_cycle", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic drive_bits(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx = v;
        end
    endtask

    // Drives start + 8 data bits, an optional low stop of stop_low_bits
    // bit-times, then one high bit-time. The reference expectation is queued
    // when the start edge goes out.
    task automatic send_frame(input logic [7:0] data, input int stop_low_bits,
                              input bit glitch, input int kind);
        logic v;
        exp_t x;
        for (int c = 0; c < 9 * P; c++) begin
            @(posedge clk);
            #1;
            v = (c < P) ? 1'b0 : data[c / P - 1];
            if (glitch && c >= P && (c % P) == P / 2) v = ~v;
            rx = v;
            if (c == 0) begin
                x.data = data;
                case (kind)
                    K_TIMED:   begin x.due = cyc + LAT; bq.push_back(x); end
                    K_UNTIMED: begin x.due = -1;        bq.push_back(x); end
                    K_FE:      eq.push_back(K_FE);
                    K_OV:      eq.push_back(K_OV);
                    default:   ;
                endcase
            end
        end
        if (stop_low_bits > 0) drive_bits(1'b0, stop_low_bits * P);
        drive_bits(1'b1, P);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bq.size() + eq.size()) > 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        drive_bits(1'b1, 4);
        chk(name, bq.size() + eq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stop_low;
        logic [7:0] d;

        rx       = 1'b1;
        rx_ready = 1'b1;
        reset    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        drive_bits(1'b1, 4);

        // Single byte, latency check.
        send_frame(8'h55, 0, 1'b0, K_TIMED);
        drain("t1_drained");

        // Overrun: first byte held, second dropped.
        rx_ready = 1'b0;
        send_frame(8'hA3, 0, 1'b0, K_UNTIMED);
        send_frame(8'h0F, 0, 1'b0, K_OV);
        drive_bits(1'b1, 10);
        chk("t2_held_data", int'(rx_data), 8'hA3);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        drain("t2_drained");

        // Long break on the stop bit, then a good frame.
        send_frame(8'h3C, 30, 1'b0, K_FE);
        send_frame(8'h81, 0, 1'b0, K_TIMED);
        drain("t3_drained");

        // Short glitch is a false start.
        drive_bits(1'b0, 5);
        drive_bits(1'b1, 3 * P);
        chk("t4_no_valid", int'(rx_valid), 0);
        drain("t4_drained");

        // Reset mid-frame with a byte held and rx low at release.
        rx_ready = 1'b0;
        send_frame(8'h77, 0, 1'b0, K_NONE);
        drive_bits(1'b1, 4);
        chk("t5_pre_valid", int'(rx_valid), 1);
        chk("t5_pre_data", int'(rx_data), 8'h77);
        drive_bits(1'b0, P);
        for (int b = 0; b < 4; b++) drive_bits(d[0], 0);
        d = 8'hE5;
        for (int b = 0; b < 4; b++) drive_bits(d[b], P);
        drive_bits(1'b0, 10);
        reset = 1'b1;
        drive_bits(1'b0, 3);
        reset = 1'b0;
        chk("t5_reset_valid", int'(rx_valid), 0);
        chk("t5_reset_data", int'(rx_data), 0);
        rx_ready = 1'b1;
        drive_bits(1'b0, 2 * P);
        drive_bits(1'b1, 2 * P);
        send_frame(8'hC9, 0, 1'b0, K_TIMED);
        drain("t5_drained");

`ifdef UART_RX_MAJORITY_EN
        // Mid-point glitches on every data bit are voted out.
        send_frame(8'h5A, 0, 1'b1, K_TIMED);
        drain("t6_drained");
`endif

        // Randomized frames, some with bad stop bits, gaps down to zero.
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            stop_low = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(d, stop_low, 1'b0, (stop_low > 0) ? K_FE : K_TIMED);
            if ($urandom_range(0, 1) == 1) drive_bits(1'b1, int'($urandom_range(1, P)));
        end
        drain("rand_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
